// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg: shared parameters and 2-bit direction counter
// encoding for the branch target buffer and its saturating counter.
package branch_target_buffer_pkg;

    // Default table depth: a power of two from 4 to 256.
    localparam int BTB_ENTRIES = 16;

    // Architectural PC width.
    localparam int PC_W = 32;

    // 2-bit direction counter. The MSB is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,  // strongly not-taken
        CTR_WNT = 2'b01,  // weakly not-taken
        CTR_WT  = 2'b10,  // weakly taken
        CTR_ST  = 2'b11   // strongly taken
    } ctr_e;

    // Value written into a counter when an entry is allocated. The first
    // lookup after allocation predicts taken, and one not-taken outcome flips it.
    localparam ctr_e CTR_ALLOC = CTR_WT;

    // A counter predicts taken when it is in either taken state.
    function automatic logic ctr_predicts_taken(input ctr_e ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// sat_counter2: combinational next-state for a 2-bit saturating direction
// counter. It moves one step toward the resolved outcome and holds at the
// ends (ST stays ST when taken, SNT stays SNT when not taken).
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    // Step the counter one state toward the resolved direction, saturating at both ends.
    always_comb begin
        // NOTE: ctr_o gets a default before the case, so every path assigns it and no latch is inferred.
        ctr_o = ctr_i;
        case (ctr_i)
            CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating direction
// counters. The fetch PC is looked up combinationally every cycle. The
// execute stage writes resolved outcomes back through a single update port.
//
// Optional feature: define BTB_STATS_EN to build 32-bit counters of resolved
// control-flow instructions and mispredictions. When it is undefined, both
// stat outputs are tied to zero and no counter flops exist.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter  int ENTRIES = BTB_ENTRIES,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = PC_W - IDX_W - 2
) (
    input  logic            clk_i,
    input  logic            rst_i,

    // Fetch-side lookup
    input  logic [PC_W-1:0] rd_pc_i,
    output logic            rd_pred_o,
    output logic [PC_W-1:0] rd_target_o,

    // Execute-side resolution
    input  logic            upd_en_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic            upd_pred_i,

    // Statistics (zero unless BTB_STATS_EN is defined)
    output logic [31:0]     stat_branch_o,
    output logic [31:0]     stat_mispred_o
);

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    ctr_e               ctr_q    [ENTRIES];

    // ------------------------------------------------------------------
    // PC decomposition. Instructions are word aligned, so pc[1:0] takes no part
    // in indexing or tagging.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;

    assign rd_idx  = rd_pc_i[IDX_W+1:2];
    assign rd_tag  = rd_pc_i[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[PC_W-1:IDX_W+2];

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

    // ------------------------------------------------------------------
    // Lookup: zero-latency read of registered state. There is no bypass from
    // the update port, so a same-cycle update is seen only on the next cycle.
    // ------------------------------------------------------------------
    logic rd_hit;

    // Tag compare and prediction for the current fetch PC.
    always_comb begin
        rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_pred_o   = rd_hit && ctr_predicts_taken(ctr_q[rd_idx]);
        rd_target_o = rd_pred_o ? target_q[rd_idx] : '0;
    end

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    logic upd_fire;      // an update that is not cancelled by reset
    logic upd_hit;       // resolved PC currently owns its entry
    logic upd_train;     // hit: step the counter, and refresh the target if taken
    logic upd_alloc;     // taken miss: claim the entry
    ctr_e upd_ctr_next;

    assign upd_fire  = upd_en_i && !rst_i;
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_train = upd_fire && upd_hit;
    assign upd_alloc = upd_fire && !upd_hit && upd_taken_i;

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[upd_idx]),
        .taken_i (upd_taken_i),
        .ctr_o   (upd_ctr_next)
    );

    // Valid bits: cleared by reset, set when a taken miss allocates an entry.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values; = would let later reads see this edge's write.
        if (rst_i) begin
            valid_q <= '0;
        end else if (upd_alloc) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Tag, target and counter storage: train on a hit, overwrite on allocation.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage arrays get no reset. valid_q masks stale contents, and leaving them unreset lets them map onto RAM.
        if (upd_train) begin
            ctr_q[upd_idx] <= upd_ctr_next;
            if (upd_taken_i) begin
                target_q[upd_idx] <= upd_target_i;
            end
        end else if (upd_alloc) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target_i;
            ctr_q[upd_idx]    <= CTR_ALLOC;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BTB_STATS_EN
    logic        mispred;
    logic [31:0] stat_branch_q;
    logic [31:0] stat_branch_d;
    logic [31:0] stat_mispred_q;
    logic [31:0] stat_mispred_d;

    // Mispredict check and next counter values. Both counters wrap naturally at 2^32.
    always_comb begin
        // A direction mismatch is a mispredict. So is a correct taken
        // prediction whose stored target is stale or was evicted.
        mispred = (upd_pred_i ^ upd_taken_i) ||
                  (upd_pred_i && upd_taken_i &&
                   (!upd_hit || (target_q[upd_idx] != upd_target_i)));

        stat_branch_d  = stat_branch_q;
        stat_mispred_d = stat_mispred_q;
        if (upd_en_i) begin
            stat_branch_d = stat_branch_q + 32'd1;
            if (mispred) begin
                stat_mispred_d = stat_mispred_q + 32'd1;
            end
        end
    end

    // Counter registers: reset clears them, and an update during reset is not counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_branch_q  <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_branch_q  <= stat_branch_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_branch_o  = stat_branch_q;
    assign stat_mispred_o = stat_mispred_q;
`else
    logic unused_upd_pred;
    assign unused_upd_pred = upd_pred_i;

    assign stat_branch_o  = '0;
    assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: scoreboard-driven bench for branch_target_buffer
// at the default depth of 16. Expected lookup and stat values are pushed when
// stimulus is applied, then popped and compared on the falling clock edge.
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    typedef struct packed {
        logic        pred;
        logic [31:0] target;
    } look_t;

    typedef struct packed {
        logic [31:0] branches;
        logic [31:0] mispreds;
    } stat_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] rd_pc_i;
    logic        rd_pred_o;
    logic [31:0] rd_target_o;
    logic        upd_en_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_i;
    logic [31:0] stat_branch_o;
    logic [31:0] stat_mispred_o;

    look_t sb_look[$];
    stat_t sb_stat[$];
    int    checks = 0;
    int    errors = 0;

    branch_target_buffer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rd_pc_i        (rd_pc_i),
        .rd_pred_o      (rd_pred_o),
        .rd_target_o    (rd_target_o),
        .upd_en_i       (upd_en_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i),
        .upd_pred_i     (upd_pred_i),
        .stat_branch_o  (stat_branch_o),
        .stat_mispred_o (stat_mispred_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Pulse one update across a rising edge.
    task automatic drive_update(input logic [31:0] pc, input logic taken,
                                input logic [31:0] tgt, input logic pred);
        upd_en_i     = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = taken;
        upd_target_i = tgt;
        upd_pred_i   = pred;
        step();
        upd_en_i     = 1'b0;
        upd_pc_i     = '0;
        upd_taken_i  = 1'b0;
        upd_target_i = '0;
        upd_pred_i   = 1'b0;
    endtask

    // Present a lookup PC and record what it must return.
    task automatic push_lookup(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        rd_pc_i = pc;
        sb_look.push_back('{pred: pred, target: tgt});
    endtask

    task automatic test_reset();
        logic [31:0] pcs [4] = '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0140};
        look_t exp;
        rst_i = 1'b1;
        repeat (2) step();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_lookup(pcs[i], 1'b0, 32'h0);
            @(negedge clk_i);
            exp = sb_look.pop_front();
            checks++;
            if ({rd_pred_o, rd_target_o} !== exp) begin
                errors++;
                $display("FAIL reset_lookup pc=%h: got pred=%0b target=%h, expected pred=%0b target=%h",
                         pcs[i], rd_pred_o, rd_target_o, exp.pred, exp.target);
            end
            step();
        end
        @(negedge clk_i);
        checks++;
        if ({stat_branch_o, stat_mispred_o} !== 64'h0) begin
            errors++;
            $display("FAIL reset_stats: got branch=%0d mispred=%0d, expected 0 0", stat_branch_o, stat_mispred_o);
        end
        step();
    endtask

    task automatic test_allocate();
        logic [31:0] pcs   [3] = '{32'h0000_0100, 32'h0000_0102, 32'h0000_0104};
        logic        preds [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] tgts  [3] = '{32'h0000_0200, 32'h0000_0200, 32'h0};
        look_t exp;
        drive_update(32'h100, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_lookup(pcs[i], preds[i], tgts[i]);
            @(negedge clk_i);
            exp = sb_look.pop_front();
            checks++;
            if ({rd_pred_o, rd_target_o} !== exp) begin
                errors++;
                $display("FAIL alloc_lookup pc=%h: got pred=%0b target=%h, expected pred=%0b target=%h",
                         pcs[i], rd_pred_o, rd_target_o, exp.pred, exp.target);
            end
            if (i == 0) begin
                checks++;
                if (dut.ctr_q[0] !== 2'b10) begin
                    errors++;
                    $display("FAIL alloc_ctr: got %b, expected 10", dut.ctr_q[0]);
                end
            end
            step();
        end
    endtask

    task automatic test_counter();
        // pc, taken, target, expected pred, expected target, expected ctr at index 0
        typedef struct packed {
            logic [31:0] pc;
            logic        taken;
            logic [31:0] tgt;
            logic        exp_pred;
            logic [31:0] exp_tgt;
            logic [1:0]  exp_ctr;
        } ctr_step_t;
        ctr_step_t steps [9] = '{
            '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   2'b01},
            '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00},
            '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   2'b00},
            '{32'h100, 1'b1, 32'h200, 1'b0, 32'h0,   2'b01},
            '{32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 2'b10},
            '{32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 2'b11},
            '{32'h100, 1'b1, 32'h204, 1'b1, 32'h204, 2'b11},
            '{32'h100, 1'b0, 32'h0,   1'b1, 32'h204, 2'b10},
            '{32'h500, 1'b0, 32'h0,   1'b1, 32'h204, 2'b10}
        };
        look_t exp;
        for (int i = 0; i < 9; i++) begin
            drive_update(steps[i].pc, steps[i].taken, steps[i].tgt, 1'b0);
            push_lookup(32'h100, steps[i].exp_pred, steps[i].exp_tgt);
            @(negedge clk_i);
            exp = sb_look.pop_front();
            checks++;
            if ({rd_pred_o, rd_target_o} !== exp) begin
                errors++;
                $display("FAIL counter_lookup step %0d: got pred=%0b target=%h, expected pred=%0b target=%h",
                         i, rd_pred_o, rd_target_o, exp.pred, exp.target);
            end
            checks++;
            if (dut.ctr_q[0] !== steps[i].exp_ctr) begin
                errors++;
                $display("FAIL counter_state step %0d: got %b, expected %b", i, dut.ctr_q[0], steps[i].exp_ctr);
            end
            step();
        end
    endtask

    task automatic test_alias();
        logic [31:0] pcs   [2] = '{32'h0000_0100, 32'h0000_0140};
        logic        preds [2] = '{1'b0, 1'b1};
        logic [31:0] tgts  [2] = '{32'h0, 32'h0000_0340};
        look_t exp;
        drive_update(32'h140, 1'b1, 32'h340, 1'b0);
        for (int i = 0; i < 2; i++) begin
            push_lookup(pcs[i], preds[i], tgts[i]);
            @(negedge clk_i);
            exp = sb_look.pop_front();
            checks++;
            if ({rd_pred_o, rd_target_o} !== exp) begin
                errors++;
                $display("FAIL alias_lookup pc=%h: got pred=%0b target=%h, expected pred=%0b target=%h",
                         pcs[i], rd_pred_o, rd_target_o, exp.pred, exp.target);
            end
            step();
        end
        @(negedge clk_i);
        checks++;
        if (dut.ctr_q[0] !== 2'b10) begin
            errors++;
            $display("FAIL alias_ctr: got %b, expected 10", dut.ctr_q[0]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        look_t exp;
        // Update and lookup of the same PC in the same cycle: old contents first.
        upd_en_i     = 1'b1;
        upd_pc_i     = 32'h180;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h380;
        upd_pred_i   = 1'b0;
        push_lookup(32'h180, 1'b0, 32'h0);
        @(negedge clk_i);
        exp = sb_look.pop_front();
        checks++;
        if ({rd_pred_o, rd_target_o} !== exp) begin
            errors++;
            $display("FAIL same_cycle_old: got pred=%0b target=%h, expected pred=%0b target=%h",
                     rd_pred_o, rd_target_o, exp.pred, exp.target);
        end
        step();
        upd_en_i = 1'b0;
        push_lookup(32'h180, 1'b1, 32'h380);
        @(negedge clk_i);
        exp = sb_look.pop_front();
        checks++;
        if ({rd_pred_o, rd_target_o} !== exp) begin
            errors++;
            $display("FAIL same_cycle_new: got pred=%0b target=%h, expected pred=%0b target=%h",
                     rd_pred_o, rd_target_o, exp.pred, exp.target);
        end
        step();
    endtask

    task automatic test_reset_with_update();
        logic [31:0] pcs [3] = '{32'h0000_0104, 32'h0000_0180, 32'h0000_0100};
        look_t exp;
        rst_i        = 1'b1;
        upd_en_i     = 1'b1;
        upd_pc_i     = 32'h104;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h999;
        upd_pred_i   = 1'b0;
        step();
        rst_i    = 1'b0;
        upd_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_lookup(pcs[i], 1'b0, 32'h0);
            @(negedge clk_i);
            exp = sb_look.pop_front();
            checks++;
            if ({rd_pred_o, rd_target_o} !== exp) begin
                errors++;
                $display("FAIL reset_update_lookup pc=%h: got pred=%0b target=%h, expected pred=%0b target=%h",
                         pcs[i], rd_pred_o, rd_target_o, exp.pred, exp.target);
            end
            step();
        end
        @(negedge clk_i);
        checks++;
        if ({stat_branch_o, stat_mispred_o} !== 64'h0) begin
            errors++;
            $display("FAIL reset_update_stats: got branch=%0d mispred=%0d, expected 0 0",
                     stat_branch_o, stat_mispred_o);
        end
        step();
    endtask

    task automatic test_stats();
        stat_t exp;
`ifdef BTB_STATS_EN
        logic [31:0] pcs   [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
        logic        tkn   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] tgts  [5] = '{32'h200, 32'h200, 32'h300, 32'h0, 32'h0};
        logic        preds [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        mis   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] n_br  = 32'd0;
        logic [31:0] n_mis = 32'd0;
        for (int i = 0; i < 5; i++) begin
            n_br  = n_br + 32'd1;
            n_mis = n_mis + {31'd0, mis[i]};
            sb_stat.push_back('{branches: n_br, mispreds: n_mis});
            drive_update(pcs[i], tkn[i], tgts[i], preds[i]);
            @(negedge clk_i);
            exp = sb_stat.pop_front();
            checks++;
            if ({stat_branch_o, stat_mispred_o} !== exp) begin
                errors++;
                $display("FAIL stats update %0d: got branch=%0d mispred=%0d, expected branch=%0d mispred=%0d",
                         i, stat_branch_o, stat_mispred_o, exp.branches, exp.mispreds);
            end
            step();
        end
        force dut.stat_branch_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branch_q;
        sb_stat.push_back('{branches: 32'h0, mispreds: n_mis});
        drive_update(32'h104, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        exp = sb_stat.pop_front();
        checks++;
        if ({stat_branch_o, stat_mispred_o} !== exp) begin
            errors++;
            $display("FAIL stats_wrap: got branch=%h mispred=%0d, expected branch=%h mispred=%0d",
                     stat_branch_o, stat_mispred_o, exp.branches, exp.mispreds);
        end
        step();
`else
        // Without the statistics build the outputs stay at zero whatever updates arrive.
        sb_stat.push_back('{branches: 32'h0, mispreds: 32'h0});
        drive_update(32'h100, 1'b1, 32'h200, 1'b0);
        @(negedge clk_i);
        exp = sb_stat.pop_front();
        checks++;
        if ({stat_branch_o, stat_mispred_o} !== exp) begin
            errors++;
            $display("FAIL stats_tied_off: got branch=%0d mispred=%0d, expected 0 0",
                     stat_branch_o, stat_mispred_o);
        end
        step();
`endif
    endtask

    initial begin
        rst_i        = 1'b1;
        rd_pc_i      = '0;
        upd_en_i     = 1'b0;
        upd_pc_i     = '0;
        upd_taken_i  = 1'b0;
        upd_target_i = '0;
        upd_pred_i   = 1'b0;

        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_back_to_back();
        test_reset_with_update();
        test_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of fetch. Each cycle it looks up the current fetch PC and predicts taken/not-taken plus a target, so the PC mux can redirect fetch without waiting for execute. The execute stage resolves control-flow instructions and writes the actual outcome back.

## Interface
Parameters:
- ENTRIES, 16: table depth; power of two, 4..256.
- IDX_W, log2(ENTRIES): index width; derived, not overridden.

Ports:
- clk_i  in  1  core clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- rd_pc_i  in  32  fetch-stage PC to look up.
- rd_pred_o  out  1  predict taken for rd_pc_i.
- rd_target_o  out  32  predicted target; 0 when rd_pred_o=0.
- upd_en_i  in  1  one-cycle pulse: execute stage resolved a branch or jump.
- upd_pc_i  in  32  PC of the resolved instruction.
- upd_taken_i  in  1  actual outcome (jumps always 1).
- upd_target_i  in  32  actual target (ALU result in execute).
- upd_pred_i  in  1  prediction that was made for this instruction, carried down the pipeline.
- stat_branch_o  out  32  resolved-control-flow count (BTB_STATS_EN only).
- stat_mispred_o  out  32  misprediction count (BTB_STATS_EN only).

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Each entry holds: valid, tag, target[31:0], ctr[1:0]. Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup is combinational from registered state: hit = valid & tag match; rd_pred_o = hit & ctr[1]; rd_target_o = rd_pred_o ? target : 0.
- Update, on the clock edge where upd_en_i=1:
  - Hit and taken: ctr saturates up (11 stays 11); target <= upd_target_i.
  - Hit and not-taken: ctr saturates down (00 stays 00); target unchanged.
  - Miss and taken: allocate the entry. valid=1, tag written, target=upd_target_i, ctr=10 (WT). Any previous occupant is overwritten.
  - Miss and not-taken: no change.
- Mispredict = upd_pred_i XOR upd_taken_i, or upd_pred_i & upd_taken_i with a target differing from the stored target. The BTB only reports mispredicts; the core does the flushing.

## Timing
- Lookup has zero latency, in the same cycle as rd_pc_i.
- An update becomes visible to lookups from the cycle after the upd_en_i edge.
- Simultaneous read and write of the same index: the read returns the pre-update contents, with no bypass.
- Reset: on an edge with rst_i=1, all valid bits and stat counters clear and any update that cycle is ignored. Next cycle rd_pred_o=0 and rd_target_o=0 for every PC. Tag, target and ctr storage need not be reset.
- Reset asserted mid-stream discards in-flight updates. The core must not pulse upd_en_i for flushed bubbles.

## Configuration
- BTB_STATS_EN defined:
  - stat_branch_o increments on each upd_en_i.
  - stat_mispred_o increments on each mispredict.
  - Both are 32-bit, wrap 0xFFFFFFFF -> 0, and clear on reset.
- BTB_STATS_EN undefined: both stat outputs are tied to 0 and no counter flops are instantiated.

## Structure
- Shared `core_param.v` gains:
  - BTB_ENTRIES default.
  - Counter state constants CTR_SNT/WNT/WT/ST.
  - Counter reset/allocate value CTR_WT.
- One sub-module, `sat_counter2`: combinational 2-bit saturating next-state, with inputs ctr and taken and output next ctr, instantiated once on the update path.
- Table arrays live in the top module.

## Test plan
- Reset, then look up rd_pc_i=0x100: rd_pred_o=0, rd_target_o=0.
- Update pc=0x100, taken, target=0x200; next cycle look up 0x100: rd_pred_o=1, rd_target_o=0x200, ctr=10.
- Two not-taken updates on 0x100: after the first, ctr=01 and rd_pred_o=0. After the second, ctr=00. A further not-taken leaves 00. Three taken updates reach 11 and saturate.
- Aliasing with ENTRIES=16: allocate 0x100, then taken update at 0x140 (same index, different tag). Lookup 0x100 misses; lookup 0x140 hits with the new target.
- Update and lookup of 0x180 in the same cycle: read shows the old contents; the next cycle shows the new ones. Assert rst_i together with upd_en_i: the update is dropped and all lookups miss.
- With BTB_STATS_EN, issue 5 updates with 2 mispredicts: stat_branch_o=5, stat_mispred_o=2. Preload 0xFFFFFFFF via force, then one update: stat_branch_o=0.
